// File: rtl/updown_cmd_sequencer.sv
// Command sequencer driving a 32-bit up/down counter: buffers run-length commands,
// dithers while idle, and keeps a cycle-accurate shadow of the counter value.
module updown_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clear,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             inst,
    output logic             ctr_reset,
    output logic [WIDTH-1:0] exp_value,
    output logic [WIDTH-1:0] base_value,
    output logic             busy,
    output logic             done
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    // Entry layout: {clear, dir, count}
    logic [CNT_W+1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    state_t           state_q, state_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] exp_value_q, exp_value_d;
    logic [WIDTH-1:0] base_value_q, base_value_d;

    logic             full, empty, push, pop;
    logic             head_clear, head_dir;
    logic [CNT_W-1:0] head_count;

    function automatic logic [WIDTH-1:0] step_value(input logic [WIDTH-1:0] v, input logic down);
        return down ? v - WIDTH'(1) : v + WIDTH'(1);
    endfunction

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign empty      = (count_q == '0);
    assign push       = cmd_valid && !full;
    assign head_clear = mem_q[rd_ptr_q][CNT_W+1];
    assign head_dir   = mem_q[rd_ptr_q][CNT_W];
    assign head_count = mem_q[rd_ptr_q][CNT_W-1:0];

    assign cmd_ready  = !full;
    assign busy       = !empty || (state_q == RUN);
    assign done       = done_q;
    assign exp_value  = exp_value_q;
    assign base_value = base_value_q;

    always_comb begin
        inst         = 1'b0;
        ctr_reset    = 1'b0;
        pop          = 1'b0;
        state_d      = state_q;
        phase_d      = phase_q;
        remaining_d  = remaining_q;
        dir_d        = dir_q;
        done_d       = 1'b0;
        base_value_d = base_value_q;

        if (reset) begin
            ctr_reset = 1'b1;
        end else if (state_q == RUN) begin
            inst        = dir_q;
            remaining_d = remaining_q - CNT_W'(1);
            if (remaining_q == CNT_W'(1)) begin
                // exp equals base on entry to RUN, so the final shadow value is the new base
                state_d      = IDLE;
                phase_d      = 1'b0;
                base_value_d = step_value(exp_value_q, dir_q);
                done_d       = 1'b1;
            end
        end else if (phase_q) begin
            inst    = 1'b1;
            phase_d = 1'b0;
        end else if (!empty && head_clear) begin
            ctr_reset    = 1'b1;
            pop          = 1'b1;
            base_value_d = '0;
            done_d       = 1'b1;
        end else if (!empty && head_count >= CNT_W'(2)) begin
            inst        = head_dir;
            pop         = 1'b1;
            dir_d       = head_dir;
            remaining_d = head_count - CNT_W'(1);
            state_d     = RUN;
        end else if (!empty && head_count == CNT_W'(1)) begin
            inst         = head_dir;
            pop          = 1'b1;
            base_value_d = step_value(base_value_q, head_dir);
            done_d       = 1'b1;
        end else begin
            if (!empty) begin
                pop    = 1'b1;
                done_d = 1'b1;
            end
            phase_d = 1'b1;
        end

        exp_value_d = ctr_reset ? '0 : step_value(exp_value_q, inst);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_q      <= 1'b0;
            remaining_q  <= '0;
            dir_q        <= 1'b0;
            done_q       <= 1'b0;
            exp_value_q  <= '0;
            base_value_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            remaining_q  <= remaining_d;
            dir_q        <= dir_d;
            done_q       <= done_d;
            exp_value_q  <= exp_value_d;
            base_value_q <= base_value_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_clear, cmd_dir, cmd_count};
        end
    end

endmodule

// File: tb/tb_updown_cmd_sequencer.sv
// Directed testbench for updown_cmd_sequencer: inputs driven and outputs sampled on the falling edge.
module tb_updown_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int WIDTH = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_clear = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             cmd_ready, inst, ctr_reset, busy, done;
    logic [WIDTH-1:0] exp_value, base_value;

    int checks = 0;
    int errors = 0;

    updown_cmd_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_clear  (cmd_clear),
        .cmd_dir    (cmd_dir),
        .cmd_count  (cmd_count),
        .inst       (inst),
        .ctr_reset  (ctr_reset),
        .exp_value  (exp_value),
        .base_value (base_value),
        .busy       (busy),
        .done       (done)
    );

    always #5 clock = ~clock;

    // Leaves the bench 1 time unit into the first cycle after reset release.
    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_clear = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            checks++; if (ctr_reset !== 1'b1) begin errors++; $display("FAIL reset_ctr_reset: got %b want 1", ctr_reset); end
            checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
            checks++; if (inst !== 1'b0) begin errors++; $display("FAIL reset_inst: got %b want 0", inst); end
        end
        checks++; if (exp_value !== '0) begin errors++; $display("FAIL reset_exp: got %h want 0", exp_value); end
        checks++; if (base_value !== '0) begin errors++; $display("FAIL reset_base: got %h want 0", base_value); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clock);
            checks++; if (inst !== i[0]) begin errors++; $display("FAIL dither_inst[%0d]: got %b want %b", i, inst, i[0]); end
            checks++; if (exp_value !== WIDTH'(i % 2)) begin errors++; $display("FAIL dither_exp[%0d]: got %h want %h", i, exp_value, i % 2); end
            checks++; if (base_value !== '0) begin errors++; $display("FAIL dither_base[%0d]: got %h want 0", i, base_value); end
            checks++; if (ctr_reset !== 1'b0) begin errors++; $display("FAIL dither_ctr_reset[%0d]: got %b want 0", i, ctr_reset); end
        end
    endtask

    task automatic test_up_run();
        apply_reset();
        @(negedge clock);
        cmd_clear = 1'b0; cmd_dir = 1'b0; cmd_count = 16'd5; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clock);
            checks++; if (inst !== 1'b0) begin errors++; $display("FAIL up_inst[%0d]: got %b want 0", i, inst); end
            checks++; if (exp_value !== WIDTH'(i)) begin errors++; $display("FAIL up_exp[%0d]: got %h want %h", i, exp_value, i); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL up_busy[%0d]: got %b want 1", i, busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL up_done_early[%0d]: got %b want 0", i, done); end
        end
        @(negedge clock);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL up_done: got %b want 1", done); end
        checks++; if (base_value !== 32'd5) begin errors++; $display("FAIL up_base: got %h want 5", base_value); end
        checks++; if (exp_value !== 32'd5) begin errors++; $display("FAIL up_exp_end: got %h want 5", exp_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL up_busy_end: got %b want 0", busy); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++; if (exp_value !== ((i % 2 == 0) ? 32'd6 : 32'd5)) begin errors++; $display("FAIL up_dither_exp[%0d]: got %h want %0d", i, exp_value, (i % 2 == 0) ? 6 : 5); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL up_done_once[%0d]: got %b want 0", i, done); end
        end
    endtask

    task automatic test_down_run();
        apply_reset();
        @(negedge clock);
        cmd_clear = 1'b0; cmd_dir = 1'b1; cmd_count = 16'd3; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            checks++; if (inst !== 1'b1) begin errors++; $display("FAIL down_inst[%0d]: got %b want 1", i, inst); end
            checks++; if (exp_value !== (32'd0 - WIDTH'(i))) begin errors++; $display("FAIL down_exp[%0d]: got %h want %h", i, exp_value, 32'd0 - WIDTH'(i)); end
        end
        @(negedge clock);
        checks++; if (exp_value !== 32'hFFFF_FFFD) begin errors++; $display("FAIL down_exp_end: got %h want fffffffd", exp_value); end
        checks++; if (base_value !== 32'hFFFF_FFFD) begin errors++; $display("FAIL down_base: got %h want fffffffd", base_value); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL down_done: got %b want 1", done); end
        @(negedge clock);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL down_done_pulse: got %b want 0", done); end
        checks++; if (exp_value !== 32'hFFFF_FFFE) begin errors++; $display("FAIL down_dither: got %h want fffffffe", exp_value); end
    endtask

    // A leading up-6 command keeps the sequencer in RUN so the queue can fill.
    task automatic test_back_to_back();
        logic             tbl_clear [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic             tbl_dir   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [CNT_W-1:0] tbl_cnt   [5] = '{16'd2, 16'd1, 16'd0, 16'd1, 16'd0};
        logic [WIDTH-1:0] exp_base  [6] = '{32'd6, 32'd8, 32'd7, 32'd7, 32'd8, 32'd0};
        int   pushes = 0;
        int   ndone = 0;
        int   nrst = 0;
        logic will_push;
        apply_reset();
        @(negedge clock);
        cmd_clear = 1'b0; cmd_dir = 1'b0; cmd_count = 16'd6; cmd_valid = 1'b1;
        @(negedge clock);
        for (int c = 0; c < 25; c++) begin
            if (done === 1'b1) begin
                if (ndone < 6) begin
                    checks++; if (base_value !== exp_base[ndone]) begin errors++; $display("FAIL b2b_base_at_done[%0d]: got %h want %h", ndone, base_value, exp_base[ndone]); end
                end
                ndone++;
            end
            if (ctr_reset === 1'b1) nrst++;
            will_push = 1'b0;
            if (pushes < 5) begin
                cmd_clear = tbl_clear[pushes];
                cmd_dir   = tbl_dir[pushes];
                cmd_count = tbl_cnt[pushes];
                cmd_valid = 1'b1;
                will_push = cmd_ready;
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clock);
            if (will_push) begin
                pushes++;
                if (pushes == 4) begin
                    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %b want 0", cmd_ready); end
                end
            end
        end
        cmd_valid = 1'b0;
        checks++; if (pushes != 5) begin errors++; $display("FAIL b2b_pushes: got %0d want 5", pushes); end
        checks++; if (ndone != 6) begin errors++; $display("FAIL b2b_done_count: got %0d want 6", ndone); end
        checks++; if (nrst != 1) begin errors++; $display("FAIL b2b_clear_cycles: got %0d want 1", nrst); end
        checks++; if (base_value !== '0) begin errors++; $display("FAIL b2b_final_base: got %h want 0", base_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_end: got %b want 1", cmd_ready); end
    endtask

    task automatic test_clear();
        apply_reset();
        @(negedge clock);
        cmd_clear = 1'b0; cmd_dir = 1'b0; cmd_count = 16'd5; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clock);
        checks++; if (base_value !== 32'd5) begin errors++; $display("FAIL clr_base_before: got %h want 5", base_value); end
        cmd_clear = 1'b1; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_valid = 1'b0; cmd_clear = 1'b0;
        checks++; if (ctr_reset !== 1'b0) begin errors++; $display("FAIL clr_wait_ctr_reset: got %b want 0", ctr_reset); end
        checks++; if (inst !== 1'b1) begin errors++; $display("FAIL clr_wait_inst: got %b want 1", inst); end
        @(negedge clock);
        checks++; if (ctr_reset !== 1'b1) begin errors++; $display("FAIL clr_ctr_reset: got %b want 1", ctr_reset); end
        checks++; if (inst !== 1'b0) begin errors++; $display("FAIL clr_inst: got %b want 0", inst); end
        @(negedge clock);
        checks++; if (ctr_reset !== 1'b0) begin errors++; $display("FAIL clr_single_cycle: got %b want 0", ctr_reset); end
        checks++; if (exp_value !== '0) begin errors++; $display("FAIL clr_exp: got %h want 0", exp_value); end
        checks++; if (base_value !== '0) begin errors++; $display("FAIL clr_base: got %h want 0", base_value); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL clr_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_busy: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_run();
        int ndone = 0;
        int nbusy = 0;
        apply_reset();
        @(negedge clock);
        cmd_clear = 1'b0; cmd_dir = 1'b0; cmd_count = 16'd10; cmd_valid = 1'b1;
        @(negedge clock);
        cmd_dir = 1'b1; cmd_count = 16'd3;
        @(negedge clock);
        cmd_dir = 1'b0; cmd_count = 16'd2;
        @(negedge clock);
        cmd_valid = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        checks++; if (exp_value !== 32'd3) begin errors++; $display("FAIL abort_exp_before: got %h want 3", exp_value); end
        reset = 1'b1;
        #1;
        checks++; if (ctr_reset !== 1'b1) begin errors++; $display("FAIL abort_ctr_reset: got %b want 1", ctr_reset); end
        checks++; if (inst !== 1'b0) begin errors++; $display("FAIL abort_inst: got %b want 0", inst); end
        @(negedge clock);
        checks++; if (exp_value !== '0) begin errors++; $display("FAIL abort_exp: got %h want 0", exp_value); end
        checks++; if (base_value !== '0) begin errors++; $display("FAIL abort_base: got %h want 0", base_value); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b want 1", cmd_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_done: got %b want 0", done); end
        reset = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clock);
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) nbusy++;
        end
        checks++; if (ndone != 0) begin errors++; $display("FAIL abort_done_after: got %0d pulses want 0", ndone); end
        checks++; if (nbusy != 0) begin errors++; $display("FAIL abort_busy_after: got %0d cycles want 0", nbusy); end
    endtask

    initial begin
        test_reset();
        test_up_run();
        test_down_run();
        test_back_to_back();
        test_clear();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
